// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE Z-collector: element formats, control/flag
// structs and the collector FSM encoding.
package redmule_pkg;

   typedef enum logic [2:0] {
      FP32,
      FP64,
      FP16,
      FP8,
      FP16ALT
   } fp_format_e;

   function automatic int unsigned fp_width(fp_format_e fmt);
      case (fmt)
         FP32:    return 32;
         FP64:    return 64;
         FP16:    return 16;
         FP8:     return 8;
         FP16ALT: return 16;
         default: return 16;
      endcase
   endfunction

   localparam int unsigned DATA_W       = 288;
   localparam int unsigned ARRAY_HEIGHT = 4;
   localparam int unsigned Z_BITW       = fp_width(FP16);
   localparam int unsigned Z_D          = DATA_W / Z_BITW;
   localparam int unsigned Z_WIDTH_W    = $clog2(Z_D) + 1;
   localparam int unsigned Z_HEIGHT_W   = $clog2(ARRAY_HEIGHT) + 1;

   typedef struct packed {
      logic                  start;
      logic [Z_WIDTH_W-1:0]  width;
      logic [Z_HEIGHT_W-1:0] height;
   } z_collector_ctrl_t;

   typedef struct packed {
      logic busy;
      logic full;
      logic done;
   } z_collector_flgs_t;

   typedef enum logic [1:0] {
      Z_IDLE,
      Z_FILL,
      Z_DRAIN
   } z_state_e;

endpackage

// File: rtl/redmule_z_buffer_scm.sv
// H x D element store: one column of all rows written per cycle, one full
// row read combinationally.
module redmule_z_buffer_scm #(
   parameter int unsigned BITW = 16,
   parameter int unsigned H    = 4,
   parameter int unsigned D    = 18,
   localparam int unsigned CW  = (D > 1) ? $clog2(D) : 1,
   localparam int unsigned HW  = (H > 1) ? $clog2(H) : 1
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [CW-1:0]            wcol_i,
   input  logic [H-1:0][BITW-1:0]   wdata_i,
   input  logic [HW-1:0]            rrow_i,
   output logic [D-1:0][BITW-1:0]   rdata_o
);

   logic [H-1:0][D-1:0][BITW-1:0] mem_q;

   // Contents are don't-care until written, so the array carries no reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int h = 0; h < int'(H); h++) begin
            mem_q[h][wcol_i] <= wdata_i[h];
         end
      end
   end

   assign rdata_o = mem_q[rrow_i];

endmodule

// File: rtl/redmule_z_collector.sv
// Collects array result columns into a buffer, then streams it out row by
// row with columns beyond the programmed width masked to zero.
module redmule_z_collector
   import redmule_pkg::*;
#(
   parameter int unsigned  DW        = 288,
   parameter fp_format_e   FpFormat  = FP16,
   parameter int unsigned  Height    = ARRAY_HEIGHT,
   localparam int unsigned BITW      = fp_width(FpFormat)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          clear_i,
   input  z_collector_ctrl_t             ctrl_i,
   output z_collector_flgs_t             flags_o,
   input  logic                          z_valid_i,
   output logic                          z_ready_o,
   input  logic [Height-1:0][BITW-1:0]   z_i,
   output logic                          z_valid_o,
   input  logic                          z_ready_i,
   output logic [DW-1:0]                 z_o,
   output logic [DW/8-1:0]               z_strb_o
);

   localparam int unsigned D   = DW / BITW;
   localparam int unsigned CW  = (D > 1) ? $clog2(D) : 1;
   localparam int unsigned HW  = (Height > 1) ? $clog2(Height) : 1;
   localparam int unsigned WW  = Z_WIDTH_W;
   localparam int unsigned HHW = Z_HEIGHT_W;
   localparam int unsigned EB  = BITW / 8;

   z_state_e         state_q, state_d;
   logic [CW-1:0]    col_cnt_q, col_cnt_d;
   logic [HW-1:0]    row_cnt_q, row_cnt_d;
   logic [WW-1:0]    width_q, width_d;
   logic [HHW-1:0]   height_q, height_d;
   logic             done_q, done_d;
   logic             buf_we;
   logic             start_ok;
   logic [D-1:0][BITW-1:0] row_data;

   assign start_ok = (ctrl_i.width != '0) && (ctrl_i.width <= WW'(D)) &&
                     (ctrl_i.height != '0) && (ctrl_i.height <= HHW'(Height));

   // Both sides use plain valid/ready: a transfer happens on any rising edge
   // where valid and ready are both high; valid never depends on ready.
   always_comb begin
      state_d   = state_q;
      col_cnt_d = col_cnt_q;
      row_cnt_d = row_cnt_q;
      width_d   = width_q;
      height_d  = height_q;
      done_d    = 1'b0;
      z_ready_o = 1'b0;
      z_valid_o = 1'b0;
      buf_we    = 1'b0;
      unique case (state_q)
         Z_IDLE: begin
            if (ctrl_i.start && start_ok) begin
               width_d  = ctrl_i.width;
               height_d = ctrl_i.height;
               state_d  = Z_FILL;
            end
         end
         Z_FILL: begin
            z_ready_o = 1'b1;
            if (z_valid_i) begin
               buf_we = 1'b1;
               if (WW'(col_cnt_q) == width_q - WW'(1)) begin
                  col_cnt_d = '0;
                  state_d   = Z_DRAIN;
               end else begin
                  col_cnt_d = col_cnt_q + CW'(1);
               end
            end
         end
         Z_DRAIN: begin
            z_valid_o = 1'b1;
            if (z_ready_i) begin
               if (HHW'(row_cnt_q) == height_q - HHW'(1)) begin
                  row_cnt_d = '0;
                  done_d    = 1'b1;
                  state_d   = Z_IDLE;
               end else begin
                  row_cnt_d = row_cnt_q + HW'(1);
               end
            end
         end
         default: state_d = Z_IDLE;
      endcase
      // Soft clear overrides anything decided above, including a start.
      if (clear_i) begin
         state_d   = Z_IDLE;
         col_cnt_d = '0;
         row_cnt_d = '0;
         done_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= Z_IDLE;
         col_cnt_q <= '0;
         row_cnt_q <= '0;
         width_q   <= '0;
         height_q  <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_cnt_q <= col_cnt_d;
         row_cnt_q <= row_cnt_d;
         width_q   <= width_d;
         height_q  <= height_d;
         done_q    <= done_d;
      end
   end

   redmule_z_buffer_scm #(
      .BITW ( BITW   ),
      .H    ( Height ),
      .D    ( D      )
   ) i_z_buffer (
      .clk_i   ( clk_i     ),
      .we_i    ( buf_we    ),
      .wcol_i  ( col_cnt_q ),
      .wdata_i ( z_i       ),
      .rrow_i  ( row_cnt_q ),
      .rdata_o ( row_data  )
   );

   // Output row is gated by DRAIN so stale buffer data never leaks elsewhere.
   always_comb begin
      z_o      = '0;
      z_strb_o = '0;
      if (state_q == Z_DRAIN) begin
         for (int d = 0; d < int'(D); d++) begin
            if (WW'(d) < width_q) begin
               z_o[d*BITW +: BITW]  = row_data[d];
               z_strb_o[d*EB +: EB] = '1;
            end
         end
      end
   end

   assign flags_o.busy = (state_q != Z_IDLE);
   assign flags_o.full = (state_q == Z_DRAIN);
   assign flags_o.done = done_q;

endmodule

// File: tb/tb_redmule_z_collector.sv
// Bench for redmule_z_collector: table of fill/drain operations checked via
// an expected-row queue, plus clear, ignored-start and reset sequences.
module tb_redmule_z_collector;
   import redmule_pkg::*;

   localparam int H  = 4;
   localparam int D  = 18;
   localparam int BW = 16;
   localparam int DW = 288;

   logic                    clk_i = 1'b0;
   logic                    rst_ni = 1'b0;
   logic                    clear_i = 1'b0;
   z_collector_ctrl_t       ctrl_i;
   z_collector_flgs_t       flags_o;
   logic                    z_valid_i = 1'b0;
   logic                    z_ready_o;
   logic [H-1:0][BW-1:0]    z_i;
   logic                    z_valid_o;
   logic                    z_ready_i = 1'b0;
   logic [DW-1:0]           z_o;
   logic [DW/8-1:0]         z_strb_o;

   redmule_z_collector #(
      .DW       ( DW   ),
      .FpFormat ( FP16 ),
      .Height   ( H    )
   ) dut (
      .clk_i     ( clk_i     ),
      .rst_ni    ( rst_ni    ),
      .clear_i   ( clear_i   ),
      .ctrl_i    ( ctrl_i    ),
      .flags_o   ( flags_o   ),
      .z_valid_i ( z_valid_i ),
      .z_ready_o ( z_ready_o ),
      .z_i       ( z_i       ),
      .z_valid_o ( z_valid_o ),
      .z_ready_i ( z_ready_i ),
      .z_o       ( z_o       ),
      .z_strb_o  ( z_strb_o  )
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          w;
      int          h;
      int          stall;   // 0 always ready, 1 toggle 1010..., 2 random
      bit          rnd;
      bit          poke;    // try a start while draining
      logic [35:0] strb;
   } vec_t;

   vec_t            tbl [6];
   logic [DW-1:0]   exp_q [$];
   logic [BW-1:0]   model [H][D];
   int              n_vec = 0;
   int              n_err = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // driver tasks
   task automatic do_start(input int w, input int h);
      ctrl_i.start  = 1'b1;
      ctrl_i.width  = 6'(w);
      ctrl_i.height = 3'(h);
      step();
      ctrl_i.start  = 1'b0;
   endtask

   task automatic fill(input int w, input bit rnd);
      for (int c = 0; c < w; c++) begin
         z_valid_i = 1'b1;
         for (int h = 0; h < H; h++) begin
            z_i[h] = rnd ? 16'($urandom_range(0, 65535)) : 16'(h * 256 + c);
            model[h][c] = z_i[h];
         end
         #1;
         if (c == 0 || c == w - 1) check("fill_ready", z_ready_o, 1'b1);
         step();
      end
      z_valid_i = 1'b0;
   endtask

   task automatic build_exp(input int w, input int h);
      logic [DW-1:0] row;
      for (int r = 0; r < h; r++) begin
         row = '0;
         for (int c = 0; c < w; c++) row[c*BW +: BW] = model[r][c];
         exp_q.push_back(row);
      end
   endtask

   task automatic drain(input int stall, input bit poke, input logic [35:0] strb);
      int            cyc = 0;
      bit            stalled = 1'b0;
      logic [DW-1:0] hold_z = '0;
      logic [35:0]   hold_s = '0;
      logic [DW-1:0] exp_row;
      while (exp_q.size() > 0 && cyc < 200) begin
         case (stall)
            0:       z_ready_i = 1'b1;
            1:       z_ready_i = (cyc % 2 == 0);
            default: z_ready_i = 1'($urandom_range(0, 1));
         endcase
         ctrl_i.start  = poke && (cyc == 1);
         ctrl_i.width  = 6'd5;
         ctrl_i.height = 3'd1;
         #1;
         if (stalled) begin
            check("stall_z_stable", z_o, hold_z);
            check("stall_strb_stable", z_strb_o, hold_s);
         end
         if (z_valid_o && z_ready_i) begin
            exp_row = exp_q.pop_front();
            check("row_data", z_o, exp_row);
            check("row_strb", z_strb_o, strb);
         end
         stalled = z_valid_o && !z_ready_i;
         hold_z  = z_o;
         hold_s  = z_strb_o;
         step();
         ctrl_i.start = 1'b0;
         cyc++;
      end
      if (exp_q.size() > 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: %0d rows missing", exp_q.size());
         exp_q.delete();
      end
      z_ready_i = 1'b0;
   endtask

   task automatic run_op(input int i);
      do_start(tbl[i].w, tbl[i].h);
      #1;
      check("start_busy", flags_o, 3'b100);
      fill(tbl[i].w, tbl[i].rnd);
      build_exp(tbl[i].w, tbl[i].h);
      #1;
      check("first_valid", z_valid_o, 1'b1);
      check("drain_flags", flags_o, 3'b110);
      drain(tbl[i].stall, tbl[i].poke, tbl[i].strb);
      check("done_pulse", flags_o, 3'b001);
      check("done_no_valid", z_valid_o, 1'b0);
      step();
      check("done_cleared", flags_o, 3'b000);
   endtask

   initial begin
      tbl[0] = '{w: 18, h: 4, stall: 0, rnd: 1'b0, poke: 1'b0, strb: 36'hF_FFFF_FFFF};
      tbl[1] = '{w: 5,  h: 2, stall: 0, rnd: 1'b0, poke: 1'b0, strb: 36'h0_0000_03FF};
      tbl[2] = '{w: 18, h: 4, stall: 1, rnd: 1'b1, poke: 1'b0, strb: 36'hF_FFFF_FFFF};
      tbl[3] = '{w: 17, h: 3, stall: 2, rnd: 1'b1, poke: 1'b0, strb: 36'h3_FFFF_FFFF};
      tbl[4] = '{w: 1,  h: 1, stall: 0, rnd: 1'b1, poke: 1'b0, strb: 36'h0_0000_0003};
      tbl[5] = '{w: 3,  h: 4, stall: 1, rnd: 1'b1, poke: 1'b1, strb: 36'h0_0000_003F};

      ctrl_i = '0;
      z_i    = '0;
      #3;
      check("reset_valid", z_valid_o, 1'b0);
      check("reset_ready", z_ready_o, 1'b0);
      check("reset_flags", flags_o, 3'b000);
      check("reset_strb", z_strb_o, '0);
      repeat (2) step();
      rst_ni = 1'b1;
      step();

      for (int i = 0; i < 6; i++) run_op(i);

      // start requests with illegal sizes never leave IDLE
      do_start(0, 4);
      check("start_w0_ignored", flags_o, 3'b000);
      do_start(5, 0);
      check("start_h0_ignored", flags_o, 3'b000);
      do_start(19, 2);
      check("start_w19_ignored", flags_o, 3'b000);
      check("ignored_ready", z_ready_o, 1'b0);

      // clear on the third column handshake
      do_start(18, 4);
      for (int c = 0; c < 3; c++) begin
         z_valid_i = 1'b1;
         clear_i   = (c == 2);
         step();
      end
      clear_i   = 1'b0;
      z_valid_i = 1'b0;
      check("clear_flags", flags_o, 3'b000);
      check("clear_ready", z_ready_o, 1'b0);
      for (int k = 0; k < 3; k++) begin
         z_ready_i = 1'b1;
         #1;
         check("clear_no_valid", z_valid_o, 1'b0);
         check("clear_no_done", flags_o, 3'b000);
         step();
      end
      z_ready_i = 1'b0;

      // asynchronous reset in the middle of a drain
      do_start(4, 3);
      fill(4, 1'b1);
      z_ready_i = 1'b1;
      step();
      z_ready_i = 1'b0;
      #2;
      rst_ni = 1'b0;
      #1;
      check("arst_valid", z_valid_o, 1'b0);
      check("arst_ready", z_ready_o, 1'b0);
      check("arst_flags", flags_o, 3'b000);
      check("arst_strb", z_strb_o, '0);
      check("arst_z", z_o, '0);
      step();
      rst_ni = 1'b1;
      step();
      run_op(1);
      run_op(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/redmule_z_collector.md
REDMULE_Z_COLLECTOR -- requirements
Module: redmule_z_collector

Interface
REQ-001 SHALL have parameter DW, default 288, meaning stream word width in bits.
REQ-002 SHALL have parameter FpFormat, default FP16, meaning element format; BITW = fp_width(FpFormat).
REQ-003 SHALL have parameter Height, default ARRAY_HEIGHT, meaning array rows H; D = DW/BITW elements per word.
REQ-004 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clear_i  input  1  synchronous soft clear.
REQ-007 SHALL have port ctrl_i  input  z_collector_ctrl_t  fields start, width ($clog2(D)+1 bits), height ($clog2(H)+1 bits).
REQ-008 SHALL have port flags_o  output  z_collector_flgs_t  fields busy, full, done.
REQ-009 SHALL have port z_valid_i / z_ready_o  input / output  1 / 1  array-side column handshake.
REQ-010 SHALL have port z_i  input  H*BITW  one result element per array row ([H-1:0][BITW-1:0]).
REQ-011 SHALL have port z_valid_o / z_ready_i  output / input  1 / 1  stream-side row handshake.
REQ-012 SHALL have port z_o  output  DW  one result row, element d at bits [(d+1)*BITW-1:d*BITW].
REQ-013 SHALL have port z_strb_o  output  DW/8  byte strobe for z_o.

Function
REQ-014 SHALL implement FSM states IDLE, FILL, DRAIN.
REQ-015 IDLE: z_ready_o=0, z_valid_o=0; ctrl_i.start with width in 1..D and height in 1..H SHALL latch width/height and go to FILL; start with width=0 or height=0 SHALL be ignored.
REQ-016 FILL: z_ready_o=1; each z_valid_i&&z_ready_o SHALL write z_i[h] into storage element (row h, column col_cnt) for all h, then increment col_cnt.
REQ-017 Handshake on col_cnt==width-1 SHALL reset col_cnt to 0 and go to DRAIN next cycle.
REQ-018 DRAIN: z_ready_o=0, z_valid_o=1; z_o SHALL present stored row row_cnt combinationally from storage, zero in columns d>=width.
REQ-019 z_strb_o bits for bytes of columns d<width SHALL be 1, others 0.
REQ-020 Each z_valid_o&&z_ready_i SHALL increment row_cnt; handshake at row_cnt==height-1 SHALL reset row_cnt to 0, go to IDLE, and pulse flags_o.done for exactly one cycle.
REQ-021 While z_valid_o=1 and z_ready_i=0, z_o and z_strb_o SHALL remain stable.
REQ-022 ctrl_i.start outside IDLE SHALL be ignored; latched width/height SHALL not change mid-operation.
REQ-023 flags_o.busy SHALL be 1 in FILL and DRAIN; flags_o.full SHALL be 1 in DRAIN only.
REQ-024 clear_i SHALL, in any state, force IDLE, zero counters and done; clear_i wins over simultaneous start or handshakes; storage contents need not be cleared.
REQ-025 Rows h>=height SHALL be written but never emitted; columns >=width SHALL be masked regardless of stale content.
REQ-026 Latency: first z_valid_o SHALL assert one cycle after the last FILL handshake; back-to-back rows SHALL drain at one per cycle with z_ready_i=1.

Reset
REQ-027 On rst_ni low SHALL enter IDLE, col_cnt=row_cnt=0, latched width/height=0, z_valid_o=0, z_ready_o=0, flags_o all 0, z_strb_o=0.
REQ-028 Reset asserted mid-FILL or mid-DRAIN SHALL abort immediately; no further handshakes until a new start.

Structure
REQ-029 z_collector_ctrl_t and z_collector_flgs_t SHALL be declared in redmule_pkg.
REQ-030 Storage SHALL be a sub-module redmule_z_buffer_scm (H rows x D columns of BITW, column write of all rows, single-row read).

Verification (H=4, D=18, FP16)
REQ-031 start width=18 height=4, 18 columns z_i[h]=16'h(h*0x100+col), z_ready_i=1 -> 4 rows, row h element c = h*0x100+c, strb all 1, done one cycle after 4th handshake.
REQ-032 width=5 height=2 -> 5 FILL handshakes, 2 rows emitted, elements 5..17 zero, z_strb_o=36'h0_0000_03FF.
REQ-033 z_ready_i toggled 1010... during DRAIN -> z_o stable while stalled, rows emitted in order, no row lost/duplicated.
REQ-034 clear_i asserted on 3rd FILL handshake -> IDLE next cycle, z_ready_o=0, no z_valid_o, done stays 0.
REQ-035 start with width=0, and start during DRAIN -> both ignored, state and latched sizes unchanged.
REQ-036 rst_ni pulsed low mid-DRAIN -> all outputs 0 asynchronously; new start afterward completes normally.
